router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet source for the 1x3 router: buffers a payload from an upstream byte stream, then drives the router input port with header, payload and parity bytes while honouring the router's `busy` back-pressure. It is the transmitting end of the router's `pkt_valid`/`data_in` packet interface. It is used as the packet generator on the router input side and as the driver in system-level benches.

## Interface
- `MAX_LEN`, 63: maximum payload length in bytes; the header field is 6 bits wide, so this is fixed at 63.
- `clock`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous active-low reset
- `start`  in  1  request a packet; sampled only when `ready`=1
- `dest_addr`  in  2  destination port 0..2; 3 is illegal
- `pay_len`  in  6  payload length 1..63; 0 is illegal
- `par_corrupt`  in  1  sampled with `start`; inverts the sent parity byte
- `pay_data`  in  8  upstream payload byte
- `pay_valid`  in  1  `pay_data` valid
- `pay_ready`  out  1  block accepts payload; high in LOAD only
- `busy`  in  1  router stall; high holds the current output byte
- `pkt_valid`  out  1  router `pkt_valid`
- `data_out`  out  8  router `data_in`
- `ready`  out  1  high in IDLE
- `tx_done`  out  1  one-cycle pulse after the parity byte transfers
- `start_err`  out  1  one-cycle pulse when `start` is rejected

## Operation
- Header byte = {pay_len[5:0], dest_addr[1:0]}.
- Parity = XOR of the header and all payload bytes, inverted if `par_corrupt` was set.
- FSM states: IDLE, LOAD, HDR, PLD, PAR.
- IDLE: `start` with `dest_addr`≠3 and `pay_len`≠0:
  - latch the header, length and corrupt flag;
  - initialise the parity accumulator to the header value;
  - go to LOAD.
- IDLE: `start` with an illegal `dest_addr` or `pay_len`: pulse `start_err`, stay in IDLE.
- LOAD: every cycle with `pay_valid`&`pay_ready`:
  - write the byte to buffer[wr_cnt];
  - XOR it into the parity accumulator;
  - increment wr_cnt.
- LOAD exit: on the edge accepting byte number `pay_len`, go to HDR. `pay_ready` drops in the same cycle the state leaves LOAD.
- Transfer: any rising edge in HDR, PLD or PAR with `busy`=0. While `busy`=1, `data_out`, `pkt_valid` and the state all hold.
- HDR: `pkt_valid`=1, `data_out`=header. On transfer, go to PLD with `data_out`=buffer[0].
- PLD: `pkt_valid`=1. On transfer, advance rd_cnt. After the transfer of byte `pay_len`−1, go to PAR with `pkt_valid`=0 and `data_out`=parity.
- PAR: on transfer, go to IDLE with `data_out`=0 and pulse `tx_done`.
- `start` outside IDLE is ignored. `pay_valid` outside LOAD is ignored.
- Reset (asynchronous, any time, including mid-packet):
  - state = IDLE;
  - counters and accumulator = 0;
  - `pkt_valid`, `data_out`, `pay_ready`, `tx_done`, `start_err` = 0;
  - the packet in progress is abandoned;
  - after reset, `ready` = 1.

## Timing
- All outputs are registered, except `ready` and `pay_ready`, which are decoded from the state register.
- Start accept edge → LOAD on the next cycle.
- With `pay_valid` held high, the header appears on `data_out` `pay_len`+1 cycles after the start-accept edge.
- With `busy`=0 throughout, the packet occupies exactly `pay_len`+2 consecutive cycles:
  - `pkt_valid` is high for `pay_len`+1 of them;
  - the parity cycle has `pkt_valid`=0.
- `tx_done` is high in the cycle after the parity transfer, coincident with `ready`=1. A new `start` is accepted in that same cycle.
- `busy` rising in the parity cycle holds the parity byte; `tx_done` is delayed accordingly.

## Structure
- Shared package `router_pkg`: header field widths (`LEN_W`=6, `ADDR_W`=2), `ADDR_ILLEGAL`=2'b11, FSM state enum `tx_state_t`.
- Sub-module `router_tx_buf`: 64x8 register file with one synchronous write port and an asynchronous read port, no reset on the storage.
- Counters and the FSM live in the top level.

## Test plan
- addr 1, len 3, payload 0x11/0x22/0x33, `busy`=0 → `data_out` sequence 0x0D, 0x11, 0x22, 0x33 with `pkt_valid`=1, then parity 0x0D with `pkt_valid`=0, then one `tx_done` pulse.
- Same packet with `busy`=1 for 2 cycles while 0x22 is presented → 0x22 and `pkt_valid`=1 hold for 3 cycles; the rest of the sequence is unchanged.
- addr 2, len 63, payload 0..62 with random `pay_valid` gaps → header 0xFE, 63 ordered payload bytes, parity equal to 0xFE XOR (XOR of 0..62); `pay_ready` deasserts after byte 63.
- `start` with addr 3, then `start` with len 0 → two `start_err` pulses, `pkt_valid` never asserted, `ready` stays 1.
- First packet with `par_corrupt`=1 → parity byte 0xF2. A back-to-back `start` on the `tx_done` cycle → second packet's header appears after its load phase with no lost bytes.
- `resetn` low for one cycle mid-PLD → `pkt_valid`/`data_out` go 0 immediately, `ready`=1 after release; the next packet has correct parity.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router packet interface: header field widths,
// the reserved destination code and the transmitter FSM state encoding.
package router_pkg;

  localparam int unsigned LEN_W  = 6;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_HDR,
    TX_PLD,
    TX_PAR
  } tx_state_t;

  // Header byte layout: length in the upper bits, destination in the lower bits.
  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                     input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: register file with one synchronous write port and an
// asynchronous read port. Storage is not reset.
module router_tx_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write port: capture a payload byte on the clock edge when enabled.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: loads a payload from an upstream byte stream, then
// sends header, payload and parity on the router input port under busy
// back-pressure.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN = 63
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  input  logic              par_corrupt,
  input  logic [7:0]        pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [7:0]        data_out,
  output logic              ready,
  output logic              tx_done,
  output logic              start_err
);

  tx_state_t r_state, w_state_nxt;

  logic [LEN_W-1:0] r_len, r_wr_cnt, r_rd_cnt;
  logic [7:0]       r_hdr, r_acc;
  logic             r_corrupt;

  logic             r_pkt_valid, r_tx_done, r_start_err;
  logic [7:0]       r_data_out;
  logic             w_pkt_valid_nxt, w_tx_done_nxt, w_start_err_nxt;
  logic [7:0]       w_data_out_nxt;

  logic             w_start_ok, w_pay_fire, w_load_last, w_xfer, w_pld_last;
  logic [7:0]       w_rdata, w_hdr_in;

  assign w_hdr_in    = make_header(pay_len, dest_addr);
  assign w_start_ok  = start && (dest_addr != ADDR_ILLEGAL) && (pay_len != '0);
  assign w_pay_fire  = pay_valid && (r_state == TX_LOAD);
  assign w_load_last = w_pay_fire && (r_wr_cnt == r_len - 1'b1);
  assign w_xfer      = !busy;
  // r_rd_cnt is the index of the next byte to present, so the last payload
  // byte is on the wire once it has reached the packet length.
  assign w_pld_last  = (r_rd_cnt == r_len);

  assign ready     = (r_state == TX_IDLE);
  assign pay_ready = (r_state == TX_LOAD);
  assign pkt_valid = r_pkt_valid;
  assign data_out  = r_data_out;
  assign tx_done   = r_tx_done;
  assign start_err = r_start_err;

  router_tx_buf #(
    .DEPTH (MAX_LEN + 1),
    .AW    (LEN_W)
  ) u_buf (
    .clock   (clock),
    .i_we    (w_pay_fire),
    .i_waddr (r_wr_cnt),
    .i_wdata (pay_data),
    .i_raddr (r_rd_cnt),
    .o_rdata (w_rdata)
  );

  // State and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= TX_IDLE;
      r_pkt_valid <= 1'b0;
      r_data_out  <= '0;
      r_tx_done   <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_data_out  <= w_data_out_nxt;
      r_tx_done   <= w_tx_done_nxt;
      r_start_err <= w_start_err_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      TX_IDLE: if (w_start_ok)            w_state_nxt = TX_LOAD;
      TX_LOAD: if (w_load_last)           w_state_nxt = TX_HDR;
      TX_HDR:  if (w_xfer)                w_state_nxt = TX_PLD;
      TX_PLD:  if (w_xfer && w_pld_last)  w_state_nxt = TX_PAR;
      TX_PAR:  if (w_xfer)                w_state_nxt = TX_IDLE;
      default:                            w_state_nxt = TX_IDLE;
    endcase
  end

  // Next values of the registered outputs; busy simply holds them.
  always_comb begin
    w_pkt_valid_nxt = r_pkt_valid;
    w_data_out_nxt  = r_data_out;
    w_tx_done_nxt   = 1'b0;
    w_start_err_nxt = 1'b0;
    unique case (r_state)
      TX_IDLE: if (start && !w_start_ok) w_start_err_nxt = 1'b1;
      TX_LOAD: begin
        if (w_load_last) begin
          w_pkt_valid_nxt = 1'b1;
          w_data_out_nxt  = r_hdr;
        end
      end
      TX_HDR: if (w_xfer) w_data_out_nxt = w_rdata;
      TX_PLD: begin
        if (w_xfer) begin
          if (w_pld_last) begin
            w_pkt_valid_nxt = 1'b0;
            w_data_out_nxt  = r_acc ^ {8{r_corrupt}};
          end else begin
            w_data_out_nxt  = w_rdata;
          end
        end
      end
      TX_PAR: begin
        if (w_xfer) begin
          w_data_out_nxt = '0;
          w_tx_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_pkt_valid_nxt = 1'b0;
        w_data_out_nxt  = '0;
      end
    endcase
  end

  // Packet context, load/read counters and parity accumulator.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_len     <= '0;
      r_hdr     <= '0;
      r_acc     <= '0;
      r_corrupt <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      unique case (r_state)
        TX_IDLE: begin
          if (w_start_ok) begin
            r_len     <= pay_len;
            r_hdr     <= w_hdr_in;
            r_acc     <= w_hdr_in;
            r_corrupt <= par_corrupt;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
          end
        end
        TX_LOAD: begin
          if (w_pay_fire) begin
            r_acc    <= r_acc ^ pay_data;
            r_wr_cnt <= r_wr_cnt + 1'b1;
          end
        end
        TX_HDR: if (w_xfer) r_rd_cnt <= LEN_W'(1);
        TX_PLD: if (w_xfer && !w_pld_last) r_rd_cnt <= r_rd_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: table of packets plus hand-written
// busy, back-to-back and reset sequences, with a byte-stream scoreboard.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic       par_corrupt;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       ready;
  logic       tx_done;
  logic       start_err;

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .dest_addr   (dest_addr),
    .pay_len     (pay_len),
    .par_corrupt (par_corrupt),
    .pay_data    (pay_data),
    .pay_valid   (pay_valid),
    .pay_ready   (pay_ready),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .data_out    (data_out),
    .ready       (ready),
    .tx_done     (tx_done),
    .start_err   (start_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       pv;
    logic [7:0] d;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [1:0] a;
    logic [5:0] l;
    logic       c;
    logic [7:0] base;
    logic [7:0] step;
    logic       gaps;
    logic [7:0] hdr;
    logic       err;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor: every transferred payload/header byte and the parity
  // byte (first cycle after pkt_valid falls) is checked against the queue.
  logic prev_pv = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      prev_pv = 1'b0;
    end else begin
      if ((pkt_valid && !busy) || (!pkt_valid && prev_pv)) begin
        if (q.size() == 0) begin
          chk("unexpected stream byte", {23'd0, pkt_valid, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("stream pkt_valid", pkt_valid, e.pv);
          chk("stream data_out", data_out, e.d);
        end
      end
      prev_pv = pkt_valid;
    end
  end

  task automatic start_and_load(input logic [1:0] a, input logic [5:0] l, input logic c,
                                input logic [7:0] base, input logic [7:0] step,
                                input logic gaps, input logic [7:0] hdr);
    logic [7:0] par, b;
    logic       v, pr;
    int         i, n;
    par = hdr;
    q.push_back('{pv: 1'b1, d: hdr});
    for (int k = 0; k < int'(l); k++) begin
      b = 8'(base + 8'(k) * step);
      par ^= b;
      q.push_back('{pv: 1'b1, d: b});
    end
    if (c) par = ~par;
    q.push_back('{pv: 1'b0, d: par});

    n = 0;
    while (!ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    chk("ready before start", ready, 1'b1);
    start = 1'b1; dest_addr = a; pay_len = l; par_corrupt = c;
    @(posedge clock); #1;
    start = 1'b0; dest_addr = 2'b11; pay_len = '0; par_corrupt = 1'b0;
    chk("start accepted", ready, 1'b0);

    i = 0; n = 0;
    while (i < int'(l) && n < 2000) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      b = 8'(base + 8'(i) * step);
      pay_valid = v;
      pay_data  = v ? b : 8'hAA;
      pr = pay_ready;
      @(posedge clock);
      if (v && pr) i++;
      #1; n++;
      if (i < int'(l)) chk("pkt_valid low in load", pkt_valid, 1'b0);
    end
    pay_valid = 1'b0;
    chk("load byte count", i, l);
    chk("pay_ready after last byte", pay_ready, 1'b0);
    chk("header pkt_valid", pkt_valid, 1'b1);
    chk("header data_out", data_out, hdr);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!tx_done && n < 500) begin
      @(posedge clock); #1; n++;
    end
    chk("tx_done seen", tx_done, 1'b1);
    chk("ready with tx_done", ready, 1'b1);
  endtask

  task automatic busy_hold(input logic pv, input logic [7:0] d, input int cycles);
    int n;
    n = 0;
    while (!(pkt_valid === pv && data_out === d) && n < 500) begin
      @(posedge clock); #1; n++;
    end
    chk("busy target found", {pkt_valid, data_out}, {pv, d});
    busy = 1'b1;
    repeat (cycles) begin
      @(posedge clock); #1;
      chk("busy hold data_out", data_out, d);
      chk("busy hold pkt_valid", pkt_valid, pv);
      chk("busy hold tx_done", tx_done, 1'b0);
    end
    busy = 1'b0;
  endtask

  task automatic bad_start(input logic [1:0] a, input logic [5:0] l);
    start = 1'b1; dest_addr = a; pay_len = l;
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_err pulse", start_err, 1'b1);
    chk("ready after bad start", ready, 1'b1);
    chk("pkt_valid after bad start", pkt_valid, 1'b0);
    @(posedge clock); #1;
    chk("start_err one cycle", start_err, 1'b0);
    chk("pkt_valid stays low", pkt_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{a: 2'd1, l: 6'd3,  c: 1'b0, base: 8'h11, step: 8'h11, gaps: 1'b0, hdr: 8'h0D, err: 1'b0};
    tbl[1] = '{a: 2'd2, l: 6'd63, c: 1'b0, base: 8'h00, step: 8'h01, gaps: 1'b1, hdr: 8'hFE, err: 1'b0};
    tbl[2] = '{a: 2'd0, l: 6'd1,  c: 1'b0, base: 8'hA5, step: 8'h00, gaps: 1'b0, hdr: 8'h04, err: 1'b0};
    tbl[3] = '{a: 2'd3, l: 6'd5,  c: 1'b0, base: 8'h00, step: 8'h00, gaps: 1'b0, hdr: 8'h00, err: 1'b1};
    tbl[4] = '{a: 2'd1, l: 6'd0,  c: 1'b0, base: 8'h00, step: 8'h00, gaps: 1'b0, hdr: 8'h00, err: 1'b1};
    tbl[5] = '{a: 2'd0, l: 6'd63, c: 1'b1, base: 8'hFF, step: 8'hFF, gaps: 1'b1, hdr: 8'hFC, err: 1'b0};

    resetn = 1'b0; start = 1'b0; dest_addr = '0; pay_len = '0; par_corrupt = 1'b0;
    pay_data = '0; pay_valid = 1'b0; busy = 1'b0;
    #12;
    chk("reset pkt_valid", pkt_valid, 1'b0);
    chk("reset data_out", data_out, 8'h00);
    chk("reset tx_done", tx_done, 1'b0);
    chk("reset start_err", start_err, 1'b0);
    chk("reset ready", ready, 1'b1);
    chk("reset pay_ready", pay_ready, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Pay data offered in IDLE must be ignored.
    pay_valid = 1'b1; pay_data = 8'h77;
    @(posedge clock); #1;
    pay_valid = 1'b0;
    chk("idle ignores pay_valid", ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].err) begin
        bad_start(tbl[i].a, tbl[i].l);
      end else begin
        start_and_load(tbl[i].a, tbl[i].l, tbl[i].c, tbl[i].base, tbl[i].step,
                       tbl[i].gaps, tbl[i].hdr);
        wait_done();
      end
    end

    // busy stall while 0x22 is on the wire.
    fork
      begin
        start_and_load(2'd1, 6'd3, 1'b0, 8'h11, 8'h11, 1'b0, 8'h0D);
        wait_done();
      end
      busy_hold(1'b1, 8'h22, 2);
    join

    // Corrupted parity held by busy, then a back-to-back packet on tx_done.
    fork
      begin
        start_and_load(2'd1, 6'd3, 1'b1, 8'h11, 8'h11, 1'b0, 8'h0D);
        wait_done();
        start_and_load(2'd2, 6'd2, 1'b0, 8'h5A, 8'h01, 1'b1, 8'h0A);
        wait_done();
      end
      busy_hold(1'b0, 8'hF2, 2);
    join

    // Reset mid-payload, then a clean packet.
    start_and_load(2'd0, 6'd8, 1'b0, 8'h40, 8'h03, 1'b0, 8'h20);
    n = 0;
    while (!(pkt_valid === 1'b1 && data_out === 8'h46) && n < 100) begin
      @(posedge clock); #1; n++;
    end
    chk("mid-payload byte reached", data_out, 8'h46);
    resetn = 1'b0;
    #1;
    chk("async reset pkt_valid", pkt_valid, 1'b0);
    chk("async reset data_out", data_out, 8'h00);
    q.delete();
    @(posedge clock); #1;
    resetn = 1'b1;
    chk("ready after reset", ready, 1'b1);
    start_and_load(2'd1, 6'd3, 1'b0, 8'h11, 8'h11, 1'b0, 8'h0D);
    wait_done();

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
